lockin_demodulator: RTL and testbench
=====================================

Name: lockin_demodulator

Overview:
- Downstream consumer of cascade_low_pass_filter output in the OPO locking chain.
- Multiplies each valid filtered sample by the sine_gen reference (sine and cosine) and integrates the products over a power-of-two window.
- Emits in-phase/quadrature sums and scaled averages, one result per window, for the lock servo.
- Signed two's-complement datapath; fully pipelined; accepts one sample per clock.

Parameters:
WORD_WIDTH, 16, width of sample and reference words (signed)
ACC_WIDTH, 48, accumulator/sum width; must be >= 2*WORD_WIDTH+12
MAX_WINDOW_LOG2, 12, largest window exponent honoured; larger requests clamp

Ports:
clk  in  1  system clock (250 MHz)
rst  in  1  asynchronous, active-high reset
enable  in  1  run demodulation; low = idle, discard partial window
window_log2  in  4  window length exponent; window = 2^window_log2 valid samples
sample_in  in  WORD_WIDTH  filtered sample, signed
sample_valid  in  1  sample_in qualifier
ref_sin  in  WORD_WIDTH  reference sine, signed, aligned with sample_in
ref_cos  in  WORD_WIDTH  reference cosine, signed, aligned with sample_in
i_sum  out  ACC_WIDTH  sum of sample*ref_sin over last window
q_sum  out  ACC_WIDTH  sum of sample*ref_cos over last window
i_avg  out  WORD_WIDTH  i_sum >>> (window_log2 + WORD_WIDTH-1)
q_avg  out  WORD_WIDTH  q_sum >>> (window_log2 + WORD_WIDTH-1)
result_valid  out  1  one-cycle pulse when outputs update
busy  out  1  high while a window is partially accumulated

Behaviour:
- Reset (async, rst=1): all outputs 0, accumulators 0, sample counter 0, pipeline valids 0, state IDLE. Takes effect without a clock edge.
- States: IDLE, RUN.
  - IDLE -> RUN when enable=1.
  - RUN -> IDLE when enable=0: partial window and in-flight pipeline discarded; no result_valid; outputs hold their last values.
- Pipeline:
  - S1 registers sample_in, ref_sin, ref_cos, sample_valid (and enable).
  - S2 forms two signed 2*WORD_WIDTH-bit products.
  - S3 adds them into sign-extended ACC_WIDTH accumulators.
- Window length:
  - Exponent latched from window_log2 when the first sample of each window enters S1.
  - Values > MAX_WINDOW_LOG2 clamp to MAX_WINDOW_LOG2.
  - 0 means a 1-sample window.
  - Changing window_log2 mid-window has no effect until the next window.
- Only cycles with sample_valid=1 count; gaps of any length are allowed.
- Latency: the last valid sample of a window, presented at edge t, produces result_valid=1 for exactly one cycle after edge t+3, with i_sum/q_sum/i_avg/q_avg updated on that same edge.
- Back-to-back windows: the accumulator reloads with the first product of the next window on the same edge it dumps. No samples are lost; throughput is 1 sample/clock.
- Averages: arithmetic right shift of the sum by (latched exponent + WORD_WIDTH-1), then reduced to WORD_WIDTH (saturating or wrapping; see Optional Feature).
- busy: 1 from the first valid sample of a window until the dump; 0 in IDLE.
- Overflow: ACC_WIDTH sized so the sum cannot overflow at MAX_WINDOW_LOG2; no wrap handling needed.
- sample_valid while enable=0: ignored.

Optional Feature:
- Macro LOCKIN_AVG_SAT_EN.
- Defined: i_avg/q_avg saturate to [-2^(WORD_WIDTH-1), 2^(WORD_WIDTH-1)-1] when the shifted sum is out of range.
- Undefined: shifted sum truncated to low WORD_WIDTH bits (wraps). i_sum/q_sum are unaffected either way.

Test Plan:
1. window_log2=2, enable=1, 4 consecutive valids with sample=16384, ref_sin=16384, ref_cos=0 -> result_valid 3 cycles after 4th sample; i_sum=1073741824, i_avg=8192, q_sum=0, q_avg=0.
2. window_log2=0, sample=-32768, ref_sin=-32768 -> i_sum=1073741824; i_avg=32767 with LOCKIN_AVG_SAT_EN, -32768 without.
3. window_log2=2, drop enable after 2 valid samples, re-enable, then feed 4 samples of 1000*1000 (ref_sin=1000) -> no pulse for the aborted window; next pulse shows i_sum=4000000.
4. window_log2=3, sample_valid every 3rd cycle, sample=100, ref_cos=-200 -> pulse 3 cycles after 8th valid; q_sum=-160000, busy high throughout the window.
5. Continuous valids, window_log2=1, constant products of 2^20 -> result_valid every 2 cycles; each i_sum=2097152; no sample dropped across 10 windows.
6. window_log2=15 -> clamps to 12; pulse after 4096th valid sample. Assert rst mid-window -> all outputs and busy read 0 before the next clk edge.

Source files
------------

// File: rtl/lockin_demodulator.sv
// Lock-in demodulator: sample x sin/cos reference, integrated over 2^N valid samples.
// Define LOCKIN_AVG_SAT_EN to saturate i_avg/q_avg; otherwise they wrap.
module lockin_demodulator #(
  parameter int WORD_WIDTH      = 16,
  parameter int ACC_WIDTH       = 48,
  parameter int MAX_WINDOW_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [3:0]            window_log2,
  input  logic [WORD_WIDTH-1:0] sample_in,
  input  logic                  sample_valid,
  input  logic [WORD_WIDTH-1:0] ref_sin,
  input  logic [WORD_WIDTH-1:0] ref_cos,
  output logic [ACC_WIDTH-1:0]  i_sum,
  output logic [ACC_WIDTH-1:0]  q_sum,
  output logic [WORD_WIDTH-1:0] i_avg,
  output logic [WORD_WIDTH-1:0] q_avg,
  output logic                  result_valid,
  output logic                  busy
);
  localparam int CW = MAX_WINDOW_LOG2 + 1;
  localparam logic [3:0] MAXE = 4'(MAX_WINDOW_LOG2);
  localparam logic signed [ACC_WIDTH-1:0] AVG_MAX = ACC_WIDTH'((64'sd1 <<< (WORD_WIDTH-1)) - 64'sd1);
  localparam logic signed [ACC_WIDTH-1:0] AVG_MIN = -AVG_MAX - ACC_WIDTH'(1);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state;

  logic [CW-1:0] cnt;
  logic [3:0]    exp_cur, exp_eff, wl_clamp;
  logic          is_last;

  logic [1:0]                          vld_pipe;  // [0] = S1, [1] = S2
  logic signed [WORD_WIDTH-1:0]        s1_x, s1_sin, s1_cos;
  logic                                s1_last, s2_last;
  logic [3:0]                          s1_exp, s2_exp, dump_exp;
  logic signed [2*WORD_WIDTH-1:0]      prod_i, prod_q;
  logic signed [ACC_WIDTH-1:0]         acc_i, acc_q;
  logic                                dump_pend;

  // Window exponent is frozen on the first sample of each window.
  assign wl_clamp = (window_log2 > MAXE) ? MAXE : window_log2;
  assign exp_eff  = (cnt == '0) ? wl_clamp : exp_cur;
  assign is_last  = (cnt + CW'(1)) == (CW'(1) << exp_eff);

  assign busy = (state == RUN) && ((|cnt) || (|vld_pipe) || dump_pend);

  function automatic logic [WORD_WIDTH-1:0] scale(input logic signed [ACC_WIDTH-1:0] s,
                                                  input logic [3:0] e);
    logic signed [ACC_WIDTH-1:0] sh;
    sh = s >>> ({2'b0, e} + 6'(WORD_WIDTH-1));
`ifdef LOCKIN_AVG_SAT_EN
    if (sh > AVG_MAX)      sh = AVG_MAX;
    else if (sh < AVG_MIN) sh = AVG_MIN;
`endif
    return sh[WORD_WIDTH-1:0];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      exp_cur      <= '0;
      vld_pipe     <= '0;
      s1_x         <= '0;
      s1_sin       <= '0;
      s1_cos       <= '0;
      s1_last      <= 1'b0;
      s1_exp       <= '0;
      s2_last      <= 1'b0;
      s2_exp       <= '0;
      prod_i       <= '0;
      prod_q       <= '0;
      acc_i        <= '0;
      acc_q        <= '0;
      dump_pend    <= 1'b0;
      dump_exp     <= '0;
      i_sum        <= '0;
      q_sum        <= '0;
      i_avg        <= '0;
      q_avg        <= '0;
      result_valid <= 1'b0;
    end else if (!enable) begin
      // Abort: drop partial window and everything in flight, keep last results.
      state        <= IDLE;
      cnt          <= '0;
      vld_pipe     <= '0;
      dump_pend    <= 1'b0;
      acc_i        <= '0;
      acc_q        <= '0;
      result_valid <= 1'b0;
    end else begin
      state <= RUN;
      // S1
      vld_pipe[0] <= sample_valid;
      s1_x        <= sample_in;
      s1_sin      <= ref_sin;
      s1_cos      <= ref_cos;
      s1_last     <= is_last;
      s1_exp      <= exp_eff;
      if (sample_valid) begin
        cnt <= is_last ? '0 : cnt + CW'(1);
        if (cnt == '0) exp_cur <= wl_clamp;
      end
      // S2
      vld_pipe[1] <= vld_pipe[0];
      prod_i      <= s1_x * s1_sin;
      prod_q      <= s1_x * s1_cos;
      s2_last     <= vld_pipe[0] & s1_last;
      s2_exp      <= s1_exp;
      // S3: a completed window dumps while the next window's first product reloads.
      if (dump_pend) begin
        i_sum <= acc_i;
        q_sum <= acc_q;
        i_avg <= scale(acc_i, dump_exp);
        q_avg <= scale(acc_q, dump_exp);
        acc_i <= vld_pipe[1] ? ACC_WIDTH'(prod_i) : '0;
        acc_q <= vld_pipe[1] ? ACC_WIDTH'(prod_q) : '0;
      end else if (vld_pipe[1]) begin
        acc_i <= acc_i + ACC_WIDTH'(prod_i);
        acc_q <= acc_q + ACC_WIDTH'(prod_q);
      end
      result_valid <= dump_pend;
      dump_pend    <= vld_pipe[1] & s2_last;
      if (vld_pipe[1] & s2_last) dump_exp <= s2_exp;
    end
  end
endmodule

// File: tb/tb_lockin_demodulator.sv
// Bench for lockin_demodulator: queue-based window model checked every cycle, plus directed literals.
module tb_lockin_demodulator;
  localparam int W = 16;
  localparam int A = 48;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         enable = 1'b0;
  logic [3:0]   window_log2 = '0;
  logic [W-1:0] sample_in = '0, ref_sin = '0, ref_cos = '0;
  logic         sample_valid = 1'b0;
  logic [A-1:0] i_sum, q_sum;
  logic [W-1:0] i_avg, q_avg;
  logic         result_valid, busy;

  lockin_demodulator dut (
    .clk(clk), .rst(rst), .enable(enable), .window_log2(window_log2),
    .sample_in(sample_in), .sample_valid(sample_valid), .ref_sin(ref_sin), .ref_cos(ref_cos),
    .i_sum(i_sum), .q_sum(q_sum), .i_avg(i_avg), .q_avg(q_avg),
    .result_valid(result_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int ncmp = 0, nbad = 0;

  typedef struct { longint due; longint si; longint sq; int e; } pend_t;
  pend_t  pend[$];
  longint cyc = 0, pcnt = 0, psi = 0, psq = 0;
  int     pexp = 0;
  logic [A-1:0] m_isum = '0, m_qsum = '0;
  logic [W-1:0] m_iavg = '0, m_qavg = '0;
  logic   m_rv = 1'b0, m_busy = 1'b0;

  int     npulse = 0;
  longint last_isum = 0, last_qsum = 0, last_iavg = 0, last_qavg = 0;

  function automatic logic [W-1:0] mavg(input longint s, input int e);
    longint sh;
    sh = s >>> (e + W - 1);
`ifdef LOCKIN_AVG_SAT_EN
    if (sh > 32767) sh = 32767;
    if (sh < -32768) sh = -32768;
`endif
    return W'(sh);
  endfunction

  // Reference model: window sums from plain arithmetic, results due 3 edges after the last sample.
  always @(posedge clk) begin
    if (rst) begin
      pend.delete();
      pcnt = 0; psi = 0; psq = 0;
      m_isum = '0; m_qsum = '0; m_iavg = '0; m_qavg = '0; m_rv = 1'b0;
    end else begin
      cyc++;
      m_rv = 1'b0;
      if (!enable) begin
        pcnt = 0; psi = 0; psq = 0;
        pend.delete();
      end else begin
        if (pend.size() > 0 && pend[0].due == cyc) begin
          pend_t r;
          r = pend.pop_front();
          m_isum = A'(r.si); m_qsum = A'(r.sq);
          m_iavg = mavg(r.si, r.e); m_qavg = mavg(r.sq, r.e);
          m_rv = 1'b1;
        end
        if (sample_valid) begin
          longint x;
          x = longint'($signed(sample_in));
          if (pcnt == 0) pexp = (window_log2 > 12) ? 12 : int'(window_log2);
          psi += x * longint'($signed(ref_sin));
          psq += x * longint'($signed(ref_cos));
          pcnt++;
          if (pcnt == (longint'(1) << pexp)) begin
            pend.push_back('{cyc + 3, psi, psq, pexp});
            pcnt = 0; psi = 0; psq = 0;
          end
        end
      end
    end
    m_busy = (pcnt > 0) || (pend.size() > 0);
    #1;
    ncmp++;
    if ({i_sum, q_sum, i_avg, q_avg, result_valid, busy} !==
        {m_isum, m_qsum, m_iavg, m_qavg, m_rv, m_busy}) begin
      nbad++;
      $display("FAIL cycle %0d: got i_sum=%0d q_sum=%0d i_avg=%0d q_avg=%0d rv=%b busy=%b, want %0d %0d %0d %0d %b %b",
               cyc, $signed(i_sum), $signed(q_sum), $signed(i_avg), $signed(q_avg), result_valid, busy,
               $signed(m_isum), $signed(m_qsum), $signed(m_iavg), $signed(m_qavg), m_rv, m_busy);
    end
    if (result_valid) begin
      npulse++;
      last_isum = longint'($signed(i_sum)); last_qsum = longint'($signed(q_sum));
      last_iavg = longint'($signed(i_avg)); last_qavg = longint'($signed(q_avg));
    end
  end

  task automatic chk(input string name, input longint got, input longint want);
    ncmp++;
    if (got !== want) begin
      nbad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic step(input logic en, input logic v, input logic [3:0] wl,
                      input int x, input int s, input int c);
    @(negedge clk);
    enable = en; sample_valid = v; window_log2 = wl;
    sample_in = W'(x); ref_sin = W'(s); ref_cos = W'(c);
  endtask

  task automatic idle(input int n, input logic [3:0] wl);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, wl, 0, 0, 0);
  endtask

  initial begin
    int p0;
    repeat (2) @(negedge clk);
    chk("reset i_sum", longint'(i_sum), 0);
    chk("reset rv_busy", longint'({result_valid, busy}), 0);
    rst = 1'b0;

    // 1: 4 x (16384*16384), window 4
    p0 = npulse;
    for (int i = 0; i < 4; i++) step(1, 1, 2, 16384, 16384, 0);
    idle(5, 2);
    chk("t1 pulses", npulse - p0, 1);
    chk("t1 i_sum", last_isum, 1073741824);
    chk("t1 i_avg", last_iavg, 8192);
    chk("t1 q_sum", last_qsum, 0);

    // 2: single-sample window, average out of range
    step(1, 1, 0, -32768, -32768, 0);
    idle(5, 0);
    chk("t2 i_sum", last_isum, 1073741824);
`ifdef LOCKIN_AVG_SAT_EN
    chk("t2 i_avg", last_iavg, 32767);
`else
    chk("t2 i_avg", last_iavg, -32768);
`endif

    // 3: aborted window yields nothing, next window is clean
    p0 = npulse;
    step(1, 1, 2, 1000, 1000, 0);
    step(1, 1, 2, 1000, 1000, 0);
    step(0, 0, 2, 0, 0, 0);
    step(0, 1, 2, 1000, 1000, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 2, 1000, 1000, 0);
    idle(5, 2);
    chk("t3 pulses", npulse - p0, 1);
    chk("t3 i_sum", last_isum, 4000000);

    // 4: sparse valids
    for (int i = 0; i < 8; i++) begin
      step(1, 1, 3, 100, 0, -200);
      idle(2, 3);
    end
    idle(3, 3);
    chk("t4 q_sum", last_qsum, -160000);

    // 5: back-to-back 2-sample windows
    p0 = npulse;
    for (int i = 0; i < 20; i++) step(1, 1, 1, 1024, 1024, 1024);
    idle(5, 1);
    chk("t5 pulses", npulse - p0, 10);
    chk("t5 i_sum", last_isum, 2097152);

    // 6: clamp 15 -> 12
    p0 = npulse;
    for (int i = 0; i < 4095; i++)
      step(1, 1, 15, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
           int'($urandom_range(0, 65535)));
    idle(5, 15);
    chk("t6 no early pulse", npulse - p0, 0);
    step(1, 1, 15, 7, 7, 7);
    idle(4, 15);
    chk("t6 pulse", npulse - p0, 1);

    // async reset mid-window
    for (int i = 0; i < 5; i++) step(1, 1, 3, 300, 300, 300);
    #2 rst = 1'b1;
    #1;
    chk("async rst sums", longint'(i_sum | q_sum), 0);
    chk("async rst avg/flags", longint'({i_avg, q_avg, result_valid, busy}), 0);
    @(negedge clk);
    rst = 1'b0;

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] wl;
      wl = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 4));
      step(($urandom_range(0, 149) != 0), ($urandom_range(0, 9) < 7), wl,
           int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
           int'($urandom_range(0, 65535)));
    end
    idle(6, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule
